// File: rtl/pulse_interval_meter_if.sv
// Measurement handshake bundle for pulse_interval_meter: the interval plus its valid/ready pair.
interface pulse_interval_meter_if #(
  parameter int CNT_W = 16
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_interval;

  modport master (output meas_valid, output meas_interval, input meas_ready);
  modport slave  (input meas_valid, input meas_interval, output meas_ready);
endinterface

// File: rtl/pulse_interval_meter.sv
// Rising-edge interval meter with watchdog timeout, single-entry output slot and pulse counter.
// Optional min/max interval tracking is enabled by defining PULSE_INTERVAL_MINMAX_EN.
module pulse_interval_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   pulse_in,
  pulse_interval_meter_if.master meas,
  output logic                   timeout,
  output logic                   overrun,
  output logic [7:0]             pulse_count,
  output logic [CNT_W-1:0]       min_interval,
  output logic [CNT_W-1:0]       max_interval
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       pulse_count_q, pulse_count_d;
  logic             edge_evt;
  logic             capture;
  logic             handshake;

  assign edge_evt  = pulse_in && !prev_q && enable;
  assign handshake = valid_q && meas.meas_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    capture   = 1'b0;
    prev_d    = pulse_in;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (edge_evt) begin
        state_d = MEASURE;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      // An edge coinciding with cnt == TIMEOUT takes priority over the watchdog.
      if (edge_evt) begin
        capture = 1'b1;
        cnt_d   = CNT_W'(1);
      end else if (cnt_q == TIMEOUT_C) begin
        state_d   = IDLE;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_comb begin
    valid_d       = valid_q;
    interval_d    = interval_q;
    overrun_d     = overrun_q;
    pulse_count_d = pulse_count_q;
    if (edge_evt) pulse_count_d = pulse_count_q + 8'd1;
    // The slot frees up in the same cycle it is consumed, so a capture can refill it.
    if (capture) begin
      if (!valid_q || handshake) begin
        valid_d    = 1'b1;
        interval_d = cnt_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_q        <= 1'b0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      valid_q       <= 1'b0;
      interval_q    <= '0;
      overrun_q     <= 1'b0;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
      valid_q       <= valid_d;
      interval_q    <= interval_d;
      overrun_q     <= overrun_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign meas.meas_valid    = valid_q;
  assign meas.meas_interval = interval_q;
  assign timeout            = timeout_q;
  assign overrun            = overrun_q;
  assign pulse_count        = pulse_count_q;

`ifdef PULSE_INTERVAL_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Dropped captures still count toward the extremes.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (capture) begin
      if (cnt_q < min_q) min_d = cnt_q;
      if (cnt_q > max_q) max_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_interval = min_q;
  assign max_interval = max_q;
`else
  assign min_interval = '0;
  assign max_interval = '0;
`endif

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Scoreboard bench for pulse_interval_meter: directed edges, queued expected intervals, negedge monitor.
module tb_pulse_interval_meter;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic pulse_in;
  logic pulse2;
  logic timeout, overrun;
  logic [7:0] pulse_count;
  logic [CNT_W-1:0] min_interval, max_interval;
  logic timeout2, overrun2;
  logic [7:0] pulse_count2;
  logic [CNT_W-1:0] min2, max2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pc  = 0;
  logic [CNT_W-1:0] sb[$];
  logic [CNT_W-1:0] sb_exp;

  pulse_interval_meter_if #(.CNT_W(CNT_W)) mif ();
  pulse_interval_meter_if #(.CNT_W(CNT_W)) mif2 ();

  pulse_interval_meter #(.CNT_W(CNT_W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in), .meas(mif),
    .timeout(timeout), .overrun(overrun), .pulse_count(pulse_count),
    .min_interval(min_interval), .max_interval(max_interval)
  );

  pulse_interval_meter #(.CNT_W(CNT_W), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse2), .meas(mif2),
    .timeout(timeout2), .overrun(overrun2), .pulse_count(pulse_count2),
    .min_interval(min2), .max_interval(max2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic edge_pulse();
    pulse_in = 1'b1;
    if (enable) exp_pc++;
    tick();
    pulse_in = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(mif.meas_valid), 0);
    chk({tag, "_interval"}, 32'(mif.meas_interval), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_pulse_count"}, 32'(pulse_count), 0);
`ifdef PULSE_INTERVAL_MINMAX_EN
    chk({tag, "_min"}, 32'(min_interval), 32'hFFFF);
`else
    chk({tag, "_min"}, 32'(min_interval), 0);
`endif
    chk({tag, "_max"}, 32'(max_interval), 0);
  endtask

  // Monitor: every accepted measurement must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mif.meas_valid && mif.meas_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got interval %0d, required no output", mif.meas_interval);
      end else begin
        sb_exp = sb.pop_front();
        if (mif.meas_interval !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_interval: got %0d, required %0d", mif.meas_interval, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; pulse_in = 1'b0; pulse2 = 1'b0;
    mif.meas_ready = 1'b1; mif2.meas_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Reset and first edge: counted, nothing captured
    idle(8);
    edge_pulse();
    chk("first_pc", 32'(pulse_count), 1);
    chk("first_valid", 32'(mif.meas_valid), 0);

    // Periodic pulses 11 apart
    idle(10);
    sb.push_back(16'd11);
    edge_pulse();
    chk("per_valid", 32'(mif.meas_valid), 1);
    chk("per_interval", 32'(mif.meas_interval), 11);
    tick();
    chk("per_valid_fall", 32'(mif.meas_valid), 0);
    idle(9);
    sb.push_back(16'd11);
    edge_pulse();
    chk("per_valid2", 32'(mif.meas_valid), 1);
    chk("per_pc", 32'(pulse_count), 3);
    idle(2);

    // Backpressure: hold 5, drop second 5, then drain
    mif.meas_ready = 1'b0;
    enable = 1'b0; tick(); enable = 1'b1;
    edge_pulse();
    idle(4);
    sb.push_back(16'd5);
    edge_pulse();
    chk("bp_valid", 32'(mif.meas_valid), 1);
    chk("bp_interval", 32'(mif.meas_interval), 5);
    chk("bp_overrun_clear", 32'(overrun), 0);
    idle(4);
    edge_pulse();
    chk("bp_overrun", 32'(overrun), 1);
    chk("bp_hold_valid", 32'(mif.meas_valid), 1);
    chk("bp_hold_interval", 32'(mif.meas_interval), 5);
    chk("bp_pc", 32'(pulse_count), 32'(exp_pc));
    mif.meas_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(mif.meas_valid), 0);
    chk("bp_overrun_sticky", 32'(overrun), 1);

    // Watchdog on the TIMEOUT=8 instance: edge at cycle 10, strobe only in cycle 19
    pulse2 = 1'b1; tick(); pulse2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("to_strobe_c%0d", 11 + k), 32'(timeout2), (k == 8) ? 1 : 0);
      tick();
    end
    pulse2 = 1'b1; tick(); pulse2 = 1'b0;
    chk("to_no_capture", 32'(mif2.meas_valid), 0);
    chk("to_pc", 32'(pulse_count2), 2);
    idle(7);
    // Edge exactly when cnt == TIMEOUT captures TIMEOUT instead of timing out
    pulse2 = 1'b1; tick(); pulse2 = 1'b0;
    chk("to_tie_valid", 32'(mif2.meas_valid), 1);
    chk("to_tie_interval", 32'(mif2.meas_interval), 8);
    chk("to_tie_strobe", 32'(timeout2), 0);
    tick();
    chk("to_tie_strobe_next", 32'(timeout2), 0);

    // Enable drop between edges at 10 and 18
    enable = 1'b0; tick(); enable = 1'b1;
    edge_pulse();
    idle(3);
    enable = 1'b0; tick(); enable = 1'b1;
    idle(3);
    edge_pulse();
    chk("en_no_capture", 32'(mif.meas_valid), 0);
    chk("en_pc", 32'(pulse_count), 32'(exp_pc));
    idle(5);
    sb.push_back(16'd6);
    edge_pulse();
    chk("en_resume_valid", 32'(mif.meas_valid), 1);
    chk("en_resume_interval", 32'(mif.meas_interval), 6);
    tick();
    mif.meas_ready = 1'b0;
    idle(2);
    edge_pulse();
    chk("rst_pre_valid", 32'(mif.meas_valid), 1);
    chk("rst_pre_interval", 32'(mif.meas_interval), 4);

    // Reset mid-measurement with a pending measurement
    rst = 1'b1; tick(); rst = 1'b0;
    exp_pc = 0;
    chk_reset_vals("midrst");

    // Min/max over intervals 7, 3, 12
    mif.meas_ready = 1'b1;
    edge_pulse();
    idle(6);
    sb.push_back(16'd7);
    edge_pulse();
    idle(2);
    sb.push_back(16'd3);
    edge_pulse();
    idle(11);
    sb.push_back(16'd12);
    edge_pulse();
    idle(3);
`ifdef PULSE_INTERVAL_MINMAX_EN
    chk("mm_min", 32'(min_interval), 3);
    chk("mm_max", 32'(max_interval), 12);
`else
    chk("mm_min", 32'(min_interval), 0);
    chk("mm_max", 32'(max_interval), 0);
`endif
    chk("mm_pc", 32'(pulse_count), 4);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
